// File: rtl/debounced_pio_in.sv
// debounced_pio_in
// Avalon-MM input PIO for board buttons and switches. Every channel is
// synchronised, debounced by a per-channel stability counter, and edge
// detected into sticky capture flags that can raise a maskable level
// interrupt. Registers: 0 DATA (ro), 1 MASK, 2 EDGE (W1C), 3 ANYEDGE.

module debounced_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] in_port_export,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_ANYEDGE = 2'd3;

    // A level is accepted once the counter has seen DEBOUNCE_CYCLES-1
    // mismatching clocks and the input still differs on the next one.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-stage synchroniser for the asynchronous board inputs.
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_q;

    // Debounce state: accepted level and per-channel stability counter.
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Edge detection derived from the debounce acceptance decision.
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;

    // Software-visible registers.
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] anyedge_q;

    // Bus decode helpers.
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      rd_mux;

    // Bits of writedata above WIDTH have no register behind them.
    logic unused_writedata;

    assign wdata_w          = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;

    // Bring the raw inputs into the clock domain through two flops.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_port_export;
            sync_q    <= sync_meta;
        end
    end

    // Decide which channels accept a new level this clock and which edge it is.
    always_comb begin
        upd  = '0;
        rise = '0;
        fall = '0;
        ev   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync_q[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
        rise = upd & sync_q;
        fall = upd & ~sync_q;
        ev   = rise | (anyedge_q & fall);
    end

    // Per-channel debounce: count consecutive mismatches, accept after enough.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    stable[i] <= sync_q[i];
                    cnt[i]    <= '0;
                end
            end
        end
    end

    // Bits software asks to clear through a W1C write to EDGE.
    always_comb begin
        clear_bits = '0;
        if (write && (address == ADDR_EDGE)) begin
            clear_bits = wdata_w;
        end
    end

    // MASK and ANYEDGE are plain read/write registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q    <= '0;
            anyedge_q <= '0;
        end else if (write) begin
            if (address == ADDR_MASK) begin
                mask_q <= wdata_w;
            end
            if (address == ADDR_ANYEDGE) begin
                anyedge_q <= wdata_w;
            end
        end
    end

    // Sticky capture flags; a new event on the same clock beats a clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~clear_bits) | ev;
        end
    end

    // Select the register being read, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_MASK:    rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE:    rd_mux[WIDTH-1:0] = capture;
            ADDR_ANYEDGE: rd_mux[WIDTH-1:0] = anyedge_q;
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data; returns to zero whenever no read is sampled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end else begin
            readdata <= '0;
        end
    end

    // Level interrupt: registered OR of enabled capture flags.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(capture & mask_q);
        end
    end

endmodule

// File: tb/tb_debounced_pio_in.sv
// tb_debounced_pio_in
// Directed bench for debounced_pio_in with WIDTH=4, DEBOUNCE_CYCLES=8.
// Bus reads push their expected value into a queue; a monitor pops and
// compares one clock later when the read data is presented.

module tb_debounced_pio_in;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [3:0]  in_bits;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_valid;
    int      tests_run;
    int      tests_failed;

    debounced_pio_in #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .in_port_export(in_bits),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Compare one value and keep the running counts.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle, sampled at the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic rd, input logic wr, input logic [31:0] wd);
        address   = a;
        read      = rd;
        write     = wr;
        writedata = wd;
        @(posedge clk_clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        applyStimulus(a, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        applyStimulus(a, 1'b0, 1'b1, wd);
    endtask

    task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        applyStimulus(a, 1'b1, 1'b1, wd);
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check_irq(input logic exp, input string name);
        checkOutput(name, {31'b0, irq}, {31'b0, exp});
    endtask

    // Track which edges sampled a read so the monitor knows when data is due.
    always @(posedge clk_clk) begin
        rd_valid <= read && reset_reset_n;
    end

    // Monitor: pop and compare whenever read data is presented.
    always @(negedge clk_clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_read", readdata, 32'hDEAD_BEEF);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                checkOutput(e.name, readdata, e.exp);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rd_valid      = 1'b0;
        reset_reset_n = 1'b0;
        in_bits       = 4'hF;
        address       = 2'd1;
        read          = 1'b1;
        write         = 1'b1;
        writedata     = 32'hF;

        // Reset with inputs high and bus activity: outputs stay quiet.
        repeat (4) begin
            @(negedge clk_clk);
            checkOutput("reset_readdata", readdata, 32'h0);
            check_irq(1'b0, "reset_irq");
        end
        @(posedge clk_clk);
        #1;
        read          = 1'b0;
        write         = 1'b0;
        reset_reset_n = 1'b1;

        bus_read(2'd1, 32'h0, "post_reset_mask");
        bus_read(2'd2, 32'h0, "post_reset_edge");
        bus_read(2'd3, 32'h0, "post_reset_anyedge");
        for (int i = 4; i <= 10; i++) begin
            bus_read(2'd0, 32'h0, "post_reset_data_low");
        end
        bus_read(2'd0, 32'hF, "post_reset_data_high");
        bus_read(2'd2, 32'hF, "post_reset_edge_set");
        check_irq(1'b0, "post_reset_irq");
        wait_clocks(1);
        checkOutput("readdata_idle_zero", readdata, 32'h0);

        // Bring inputs low and clear flags before the channel tests.
        in_bits = 4'h0;
        wait_clocks(12);
        bus_write(2'd2, 32'hF);
        bus_read(2'd0, 32'h0, "data_all_low");
        bus_read(2'd2, 32'h0, "edge_cleared");

        // Clean rise on bit0 with MASK=0.
        in_bits = 4'h1;
        wait_clocks(9);
        bus_read(2'd0, 32'h0, "rise_data_early");
        bus_read(2'd0, 32'h1, "rise_data");
        bus_read(2'd2, 32'h1, "rise_edge");
        check_irq(1'b0, "rise_irq_masked");

        // Bounce on bit1: 3-clock pulses are rejected, final rise accepted.
        bus_write(2'd2, 32'hF);
        for (int t = 0; t < 10; t++) begin
            in_bits[1] = (t % 2 == 0) ? 1'b1 : 1'b0;
            repeat (3) bus_read(2'd0, 32'h1, "bounce_data_hold");
        end
        in_bits = 4'h3;
        wait_clocks(9);
        bus_read(2'd0, 32'h1, "bounce_data_early");
        bus_read(2'd0, 32'h3, "bounce_data_final");
        bus_read(2'd2, 32'h2, "bounce_edge");

        // Interrupt and W1C on bit0.
        in_bits = 4'h2;
        wait_clocks(12);
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'h1);
        check_irq(1'b0, "irq_idle");
        in_bits = 4'h3;
        wait_clocks(10);
        check_irq(1'b0, "irq_not_yet");
        bus_read(2'd2, 32'h1, "irq_edge_set");
        check_irq(1'b1, "irq_asserted");
        bus_write(2'd2, 32'h1);
        check_irq(1'b1, "irq_clear_edge");
        wait_clocks(1);
        check_irq(1'b0, "irq_cleared");
        bus_write(2'd2, 32'h0);
        check_irq(1'b0, "irq_w1c_zero");
        bus_read(2'd2, 32'h0, "edge_after_w1c");

        // DATA is read-only, upper bits ignored, read-during-write sees old value.
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, 32'h3, "data_read_only");
        bus_write(2'd1, 32'hFFFF_FFF1);
        bus_read(2'd1, 32'h1, "mask_width");
        bus_rw(2'd1, 32'h0, 32'h1, "rw_pre_write");
        bus_read(2'd1, 32'h0, "rw_post_write");

        // Edge mode on bit2.
        in_bits = 4'h7;
        wait_clocks(12);
        bus_write(2'd2, 32'hF);
        in_bits = 4'h3;
        wait_clocks(12);
        bus_read(2'd2, 32'h0, "fall_ignored");
        bus_read(2'd0, 32'h3, "fall_data");
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, 32'h4, "anyedge_readback");
        in_bits = 4'h7;
        wait_clocks(12);
        bus_write(2'd2, 32'hF);
        in_bits = 4'h3;
        wait_clocks(12);
        bus_read(2'd2, 32'h4, "fall_captured");

        // W1C of bit3 on the same edge as its new event: set wins.
        bus_write(2'd2, 32'hF);
        in_bits = 4'hB;
        wait_clocks(9);
        bus_write(2'd2, 32'h8);
        bus_read(2'd2, 32'h8, "collision_set_wins");

        // Reset four clocks into a debounce aborts it; latency restarts.
        in_bits = 4'hF;
        repeat (3) bus_read(2'd0, 32'hB, "abort_data_hold");
        wait_clocks(1);
        reset_reset_n = 1'b0;
        #1;
        checkOutput("abort_reset_readdata", readdata, 32'h0);
        check_irq(1'b0, "abort_reset_irq");
        wait_clocks(2);
        reset_reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus_read(2'd0, 32'h0, "restart_data_low");
        end
        bus_read(2'd0, 32'hF, "restart_data_high");
        bus_read(2'd2, 32'hF, "restart_edge");
        check_irq(1'b0, "restart_irq");

        wait_clocks(2);
        checkOutput("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debounced_pio_in.md
# debounced_pio_in

Parametrised input PIO that brings WIDTH asynchronous board inputs (push-buttons, DIP switches) into the FPGA fabric. Each input is synchronised and debounced, then edges are captured into per-channel sticky flags, and a maskable level interrupt is raised. The block is an Avalon-MM slave on the lightweight HPS-to-FPGA bridge. Compared with a plain input PIO it adds width scaling, debounce filtering, selectable edge mode and an interrupt.

## Interface
Parameters:
- WIDTH, 4: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clocks required to accept a new level, ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width (derived, not overridden).

Ports:
- clk_clk  in  1  single clock; everything is on the rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- in_port_export  in  WIDTH  raw board inputs, asynchronous to clk_clk.
- address  in  2  word address of the register.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

## Operation
- Sync: two flops per bit. The output is sync[i].
- Debounce, per bit, with a counter cnt[i] and a level stable[i]:
  - If sync[i]==stable[i]: cnt[i] goes to 0.
  - Otherwise, while cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
  - Otherwise (cnt[i]==DEBOUNCE_CYCLES-1): stable[i] takes sync[i] and cnt[i] goes to 0.
  - Result: any glitch shorter than DEBOUNCE_CYCLES clocks is rejected.
- Edge detect, per bit:
  - rise = stable update 0→1; fall = stable update 1→0.
  - ev[i] = rise | (anyedge[i] & fall).
- Register map (32-bit; bits ≥WIDTH read 0 and ignore writes):
  - 0 DATA: stable[], read-only; writes are ignored.
  - 1 MASK: irq enable per bit, RW.
  - 2 EDGE: sticky capture flags. Read returns flags; writing 1 clears that bit (W1C).
  - 3 ANYEDGE: per bit, 1 = capture both edges, 0 = rising only. RW.
- Capture set/clear:
  - capture[i] is set on the edge where ev[i]=1.
  - capture[i] is cleared on the edge of a write to address 2 with writedata[i]=1.
  - Set and clear in the same cycle on the same bit: set wins, bit stays 1.
- irq: registered copy of |(capture & MASK).
- Simultaneous read and write: both execute. The read returns the pre-write value.
- Reset values (asynchronous):
  - sync, stable, cnt, MASK, EDGE, ANYEDGE: 0.
  - readdata = 0; irq = 0.
- Reset asserted mid-debounce aborts the count. No capture from pre-reset activity.
- An input held high through reset produces one rising capture after release, at the normal latency. MASK=0 at reset, so no interrupt results until software enables it.

## Timing
- Read latency: 1 clock.
  - read sampled at edge N → readdata valid after edge N+1.
  - readdata returns to 0 after the first edge with read low.
- Write takes effect at the edge where write is sampled.
- Input latency: in_port_export stable from edge K gives sync at edge K+2.
  - stable and capture update at edge K+2+DEBOUNCE_CYCLES.
  - irq follows one edge later.
- MASK write takes effect on irq one edge after the write edge.
- W1C: irq deasserts one edge after the clearing write, unless another masked flag is set.
- No wait states; waitrequest is not provided.

## Test plan
Bench uses DEBOUNCE_CYCLES=8, WIDTH=4.
1. **Reset:** assert reset_reset_n=0 with in_port_export=0xF and activity on read/write → readdata=0 and irq=0 throughout. After release, reads of addresses 1/2/3 return 0. Read of address 0 returns 0x0 until 10 clocks, then 0xF. EDGE then reads 0xF.
2. **Clean rise:** in_port_export[0] 0→1 at edge K, MASK=0 → DATA=0x1 from edge K+10. EDGE=0x1. irq stays 0.
3. **Bounce:** in_port_export[1] toggles every 3 clocks for 30 clocks, then held 1 → DATA[1] stays 0 during toggling. DATA[1] becomes 1 exactly 10 clocks after the final transition. EDGE shows exactly 0x2 and no extra events.
4. **Interrupt/W1C:** MASK=0x1, rise on bit0 → irq=1 one clock after EDGE[0] sets. Write address 2 with 0x1 → irq=0 one clock later. Write address 2 with 0x0 → no change.
5. **Edge mode:** falling edge on bit2 with ANYEDGE=0 → EDGE[2] stays 0. With ANYEDGE=0x4, falling edge → EDGE=0x4.
6. **Collision and reset abort:**
   - W1C of bit3 lands on the same edge as a new ev[3] → EDGE[3]=1 afterward.
   - Reset pulse 4 clocks into a debounce → no DATA/EDGE change. A full 10-clock latency restarts from release.
